uart_tx_scheduler: RTL and testbench

- Memory-mapped transmit controller between the RV32I core's peripheral write path and the UART transmitter.
- Buffers bytes written by the core in a FIFO.
- Sequences the UART TX handshake (load Tx data, pulse start, track busy) one byte at a time, with a programmable inter-frame gap.
- Exposes FIFO and error status for core polling.

---
 rtl/uart_tx_scheduler_if.sv | 32 +++
 rtl/uart_tx_scheduler.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Transmit-scheduler bus: core write port, error clear, UART handshake and status.
// slave is the scheduler side, master is the core/UART side.
interface uart_tx_scheduler_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_err;
  logic          uart_busy;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_start;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          overflow;
  logic          timeout_err;
  logic          idle;

  modport slave (
    input  wr_en, wr_data, clr_err, uart_busy,
    output uart_tx_data, uart_tx_start, fifo_count, fifo_full, fifo_empty,
           overflow, timeout_err, idle
  );

  modport master (
    output wr_en, wr_data, clr_err, uart_busy,
    input  uart_tx_data, uart_tx_start, fifo_count, fifo_full, fifo_empty,
           overflow, timeout_err, idle
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Byte FIFO plus one-frame-at-a-time UART TX sequencer (load, start pulse, busy tracking, gap).
// Start pulse 3 clocks after a write into an idle block; writes into a full FIFO are dropped unless a pop coincides.
module uart_tx_scheduler #(
  parameter int DEPTH        = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_scheduler_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Flag fires on the edge exactly BUSY_TIMEOUT clocks after the start pulse rose.
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 2);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GAP
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;

  state_t        r_state;
  logic [7:0]    r_tx_data;
  logic          r_start;
  logic [TW-1:0] r_to_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic          r_tmo;
  logic          r_idle;

  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;

  assign w_pop  = (r_state == S_LOAD);
  assign w_push = bus.wr_en && (!r_full || w_pop);
  assign w_drop = bus.wr_en && !w_push;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop)
      w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      if (w_drop)
        r_ovf <= 1'b1;
      else if (bus.clr_err)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_tx_data <= '0;
      r_start   <= 1'b0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
      r_tmo     <= 1'b0;
      r_idle    <= 1'b1;
    end else begin
      r_start <= 1'b0;
      r_idle  <= 1'b0;
      // A timeout raised in this same cycle is assigned later and wins over the clear.
      if (bus.clr_err)
        r_tmo <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!r_empty)
            r_state <= S_LOAD;
          else
            r_idle <= (w_count_nxt == '0);
        end

        S_LOAD: begin
          r_tx_data <= r_mem[r_rd_ptr];
          r_start   <= 1'b1;
          r_state   <= S_START;
        end

        S_START: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT_HI;
        end

        S_WAIT_HI: begin
          if (bus.uart_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_to_cnt == TO_LAST) begin
            r_tmo <= 1'b1;
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
              r_idle  <= (w_count_nxt == '0);
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end

        S_WAIT_LO: begin
          if (!bus.uart_busy) begin
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
              r_idle  <= (w_count_nxt == '0);
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= '0;
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
            r_idle  <= (w_count_nxt == '0);
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.uart_tx_data  = r_tx_data;
  assign bus.uart_tx_start = r_start;
  assign bus.fifo_count    = r_count;
  assign bus.fifo_full     = r_full;
  assign bus.fifo_empty    = r_empty;
  assign bus.overflow      = r_ovf;
  assign bus.timeout_err   = r_tmo;
  assign bus.idle          = r_idle;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: a frame-timeline reference model checked every cycle,
// a UART busy responder, and literal expectations for latency, ordering, overflow, timeout and reset.
module tb_uart_tx_scheduler;
  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TO    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if #(.DEPTH(DEPTH)) bus();

  uart_tx_scheduler #(
    .DEPTH(DEPTH), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: FIFO as a queue, frame as a timeline ----------------
  int         cyc = 0;
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_s = 0;
  bit         m_acked = 1'b0;
  int         m_idle_at = 0;
  logic [7:0] m_txd = 8'h00;
  bit         m_ovf = 1'b0, m_tmo = 1'b0, m_start = 1'b0, m_idle = 1'b1;
  bit         m_idle_prev, m_pop, m_push, m_tmo_set;
  int         m_cnt_prev;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_active = 1'b0; m_acked = 1'b0; m_idle_at = 0; m_txd = 8'h00;
      m_ovf = 1'b0; m_tmo = 1'b0; m_start = 1'b0; m_idle = 1'b1;
    end else begin
      cyc++;
      m_cnt_prev  = m_q.size();
      m_idle_prev = !m_active && (cyc - 1 >= m_idle_at);
      m_pop       = m_active && (cyc == m_s);
      m_tmo_set   = 1'b0;
      if (m_active && m_acked) begin
        if (!bus.uart_busy) begin
          m_active = 1'b0; m_idle_at = cyc + GAP;
        end
      end else if (m_active && cyc >= m_s + 2) begin
        if (bus.uart_busy)
          m_acked = 1'b1;
        else if (cyc == m_s + TO) begin
          m_tmo_set = 1'b1; m_active = 1'b0; m_idle_at = cyc + GAP;
        end
      end
      if (m_idle_prev && m_cnt_prev > 0) begin
        m_active = 1'b1; m_s = cyc + 1; m_acked = 1'b0;
      end
      m_push = bus.wr_en && (m_cnt_prev < DEPTH || m_pop);
      if (m_pop) m_txd = m_q.pop_front();
      if (m_push) m_q.push_back(bus.wr_data);
      if (bus.wr_en && !m_push) m_ovf = 1'b1;
      else if (bus.clr_err)     m_ovf = 1'b0;
      if (m_tmo_set)            m_tmo = 1'b1;
      else if (bus.clr_err)     m_tmo = 1'b0;
      m_start = m_pop;
      m_idle  = !m_active && (cyc >= m_idle_at) && (m_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    chk("tx_data",     bus.uart_tx_data,  m_txd);
    chk("tx_start",    bus.uart_tx_start, m_start);
    chk("fifo_count",  bus.fifo_count,    m_q.size());
    chk("fifo_full",   bus.fifo_full,     m_q.size() == DEPTH);
    chk("fifo_empty",  bus.fifo_empty,    m_q.size() == 0);
    chk("overflow",    bus.overflow,      m_ovf);
    chk("timeout_err", bus.timeout_err,   m_tmo);
    chk("idle",        bus.idle,          m_idle);
  end

  // ---------------- UART busy responder and event monitors ----------------
  int         bmode = 0;   // 0: busy for blen clocks after each start, 1: held high, 2: held low
  int         blen  = 20;
  int         rem   = 0;
  logic [7:0] rx_q[$];
  int         n_start = 0, last_start = -1;
  int         idle_rise = -1, tmo_rise = -1, full_cycles = 0;
  bit         p_idle = 1'b1, p_tmo = 1'b0;

  always @(negedge clk) begin
    case (bmode)
      1: begin bus.uart_busy = 1'b1; rem = 0; end
      2: begin bus.uart_busy = 1'b0; rem = 0; end
      default: begin
        if (rem > 0) begin bus.uart_busy = 1'b1; rem--; end
        else bus.uart_busy = 1'b0;
      end
    endcase
    if (rst && bus.uart_tx_start === 1'b1) begin
      rx_q.push_back(bus.uart_tx_data);
      n_start++;
      last_start = cyc;
      rem = blen;
    end
    if (bus.idle === 1'b1 && !p_idle) idle_rise = cyc;
    if (bus.timeout_err === 1'b1 && !p_tmo) tmo_rise = cyc;
    if (bus.fifo_full === 1'b1) full_cycles++;
    p_idle = (bus.idle === 1'b1);
    p_tmo  = (bus.timeout_err === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    bus.wr_en = 1'b1; bus.wr_data = b;
    tick(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k;
    k = 0;
    while (bus.idle !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    if (bus.idle !== 1'b1) begin
      n_vec++; n_bad++;
      $display("FAIL %s: idle not reached within %0d cycles", nm, budget);
    end
  endtask

  task automatic clear_errors();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tx_data"},  bus.uart_tx_data,  0);
    chk({tag, "_tx_start"}, bus.uart_tx_start, 0);
    chk({tag, "_count"},    bus.fifo_count,    0);
    chk({tag, "_full"},     bus.fifo_full,     0);
    chk({tag, "_empty"},    bus.fifo_empty,    1);
    chk({tag, "_ovf"},      bus.overflow,      0);
    chk({tag, "_tmo"},      bus.timeout_err,   0);
    chk({tag, "_idle"},     bus.idle,          1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, n0, r0, fc0;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.clr_err = 1'b0;
    tick(3);
    chk_reset_values("reset");
    rst = 1'b1;
    tick(2);

    // Single byte, busy for 20 clocks after start.
    bmode = 0; blen = 20; n0 = n_start; r0 = rx_q.size();
    w = cyc;
    wr(8'h55);
    tick(40);
    chk("t1_pulses",  n_start - n0, 1);
    chk("t1_latency", last_start - w, 3);
    chk("t1_byte",    (rx_q.size() > r0) ? rx_q[r0] : 32'hFFFF, 8'h55);
    chk("t1_idle_at", idle_rise - last_start, 20 + GAP + 2);

    // Burst of DEPTH bytes on consecutive clocks.
    blen = 3; r0 = rx_q.size(); fc0 = full_cycles;
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i);
      tick(1);
    end
    bus.wr_en = 1'b0;
    wait_idle("t2_drain", 400);
    chk("t2_never_full", full_cycles - fc0, 0);
    chk("t2_rx_count",   rx_q.size() - r0, 8);
    for (int i = 0; i < 8; i++)
      chk("t2_order", (rx_q.size() > r0 + i) ? rx_q[r0 + i] : 32'hFFFF, i + 1);
    chk("t2_overflow", bus.overflow, 0);

    // UART held busy: fill, overflow, clear.
    bmode = 1; r0 = rx_q.size();
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + i);
      tick(1);
    end
    bus.wr_en = 1'b0;
    chk("t3_full_after9",  bus.fifo_full,  1);
    chk("t3_count_after9", bus.fifo_count, 8);
    chk("t3_ovf_before",   bus.overflow,   0);
    wr(8'h19);
    chk("t3_ovf_set",      bus.overflow,   1);
    chk("t3_count_kept",   bus.fifo_count, 8);
    clear_errors();
    chk("t3_ovf_cleared",  bus.overflow,   0);

    // Release busy; write lands exactly in the LOAD cycle of the next frame while full.
    bmode = 2;
    tick(4);
    wr(8'h1A);
    chk("t6_count",   bus.fifo_count, 8);
    chk("t6_full",    bus.fifo_full,  1);
    chk("t6_ovf",     bus.overflow,   0);
    chk("t6_popped",  bus.uart_tx_data, 8'h11);
    bmode = 0; blen = 2;
    wait_idle("t6_drain", 600);
    chk("t6_rx_count", rx_q.size() - r0, 10);
    for (int i = 0; i < 9; i++)
      chk("t6_order", (rx_q.size() > r0 + i) ? rx_q[r0 + i] : 32'hFFFF, 8'h10 + i);
    chk("t6_last", (rx_q.size() > r0 + 9) ? rx_q[r0 + 9] : 32'hFFFF, 8'h1A);

    // Busy never rises: timeout after BUSY_TIMEOUT clocks, then recovery.
    bmode = 2;
    wr(8'hA5);
    tick(30);
    chk("t4_tmo_set",   bus.timeout_err, 1);
    chk("t4_tmo_delay", tmo_rise - last_start, TO);
    chk("t4_byte",      rx_q[$], 8'hA5);
    wait_idle("t4_gap", 100);
    bmode = 0; blen = 4;
    clear_errors();
    chk("t4_tmo_clr",   bus.timeout_err, 0);
    n0 = n_start;
    wr(8'h3C);
    tick(30);
    chk("t4_recover_pulses", n_start - n0, 1);
    chk("t4_recover_byte",   rx_q[$], 8'h3C);

    // Reset during WAIT_LO with 4 bytes queued.
    bmode = 1;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h61 + i);
      tick(1);
    end
    bus.wr_en = 1'b0;
    chk("t5_queued", bus.fifo_count, 4);
    tick(2);
    #2 rst = 1'b0;
    #1 chk_reset_values("t5_async");
    n0 = n_start;
    bmode = 0; blen = 3;
    tick(2);
    rst = 1'b1;
    tick(30);
    chk("t5_no_start", n_start - n0, 0);
    chk("t5_idle",     bus.idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
